// File: rtl/fabric_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional subtract mode is enabled with FABRIC_SERIAL_ADDER_SUB_EN.
package fabric_serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ADDF.sv
// Fabric full-adder primitive: one bit of sum and carry.
module ADDF (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic SUM,
  output logic CO
);

  assign SUM = A ^ B ^ CI;
  assign CO  = (A & B) | (A & CI) | (B & CI);

endmodule

// File: rtl/fabric_serial_adder.sv
// LSB-first bit-serial adder built around a single ADDF cell.
// Define FABRIC_SERIAL_ADDER_SUB_EN to add the sub input (A - B mode).
module fabric_serial_adder
  import fabric_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef FABRIC_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_sum;
  logic             cell_co;
  logic             accept;
  logic             last_bit;
  logic             busy_next;
  logic             done_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign res_next = {cell_sum, res_sh};

`ifdef FABRIC_SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and force the initial carry.
  assign b_load     = sub ? ~op_b : op_b;
  assign carry_load = sub | cin;
`else
  assign b_load     = op_b;
  assign carry_load = cin;
`endif

  ADDF u_addf (
    .A   (a_sh[0]),
    .B   (b_sh[0]),
    .CI  (carry),
    .SUM (cell_sum),
    .CO  (cell_co)
  );

  // State register with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    busy_next = (next_state == RUN);
    done_next = (next_state == DONE);
  end

  // Serial datapath; sum/cout only change when the last bit is produced.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= op_a;
      b_sh   <= b_load;
      res_sh <= '0;
      carry  <= carry_load;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= res_next[WIDTH-1:1];
      carry  <= cell_co;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        sum  <= res_next;
        cout <= cell_co;
      end
    end
  end

endmodule

// File: tb/tb_fabric_serial_adder.sv
// Scoreboard bench for fabric_serial_adder (WIDTH=8); subtract cases run
// when FABRIC_SERIAL_ADDER_SUB_EN is defined.
module tb_fabric_serial_adder;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic [31:0]      cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] cyc = '0;
  int unsigned brun = 0;
  exp_t q[$];

  fabric_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
`ifdef FABRIC_SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: compare every done pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (busy) brun++;
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("sum", 32'(sum), 32'(e.s));
          check("cout", 32'(cout), 32'(e.c));
          check("done_cyc", cyc, e.cyc);
          check("busy_len", brun, WIDTH);
        end
      end
      if (!busy) brun = 0;
    end
  end

  // Drive one start; call just after a negedge with the block in IDLE/DONE.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s);
    logic [WIDTH:0] full;
    exp_t e;
    op_a  = a;
    op_b  = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    if (s) full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    else   full = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
    @(posedge clk);
    #1;
    start = 1'b0;
    e.s   = full[WIDTH-1:0];
    e.c   = full[WIDTH];
    e.cyc = cyc + WIDTH;
    q.push_back(e);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    reset = 1'b0;
    idle_cycles(2);

    // Basic add plus carry boundaries.
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done();
    idle_cycles(2);
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done();
    idle_cycles(1);
    start_op(8'hFF, 8'h00, 1'b1, 1'b0);
    wait_done();
    idle_cycles(1);
    check("held_sum_idle", 32'(sum), 32'h00);
    check("held_cout_idle", 32'(cout), 32'd1);

    // start during RUN is ignored.
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    idle_cycles(3);
    op_a  = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    idle_cycles(2);

    // Reset mid-RUN aborts the operation.
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    idle_cycles(4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    idle_cycles(20);
    start_op(8'h80, 8'h80, 1'b1, 1'b0);
    wait_done();

    // Back-to-back: start held in the DONE cycle.
    idle_cycles(1);
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done();
    start_op(8'h01, 8'h02, 1'b0, 1'b0);
    idle_cycles(3);
    check("b2b_held_sum", 32'(sum), 32'h00);
    check("b2b_held_cout", 32'(cout), 32'd1);
    wait_done();
    idle_cycles(2);

    // A few random additions.
    for (int i = 0; i < 4; i++) begin
      start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
      wait_done();
      idle_cycles(1);
    end

`ifdef FABRIC_SERIAL_ADDER_SUB_EN
    start_op(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done();
    idle_cycles(1);
    start_op(8'h00, 8'h01, 1'b1, 1'b1);
    wait_done();
    idle_cycles(1);
`endif

    idle_cycles(3);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fabric_serial_adder.md
FABRIC_SERIAL_ADDER -- requirements
Module: fabric_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin one serial addition; sampled only in IDLE or DONE.
REQ-005 Port: op_a  input  WIDTH  operand A; captured on an accepted start.
REQ-006 Port: op_b  input  WIDTH  operand B; captured on an accepted start.
REQ-007 Port: cin  input  1  initial carry-in; captured on an accepted start.
REQ-008 Port: busy  output  1  high while bits are being processed (RUN state).
REQ-009 Port: done  output  1  one-cycle pulse marking that sum and cout are valid.
REQ-010 Port: sum  output  WIDTH  result register; holds its value until the next accepted start.
REQ-011 Port: cout  output  1  final carry-out; holds its value until the next accepted start.

Function
REQ-012 The block SHALL use one full-adder cell for all bits: LSB-first bit-serial datapath, with the carry flop feeding cout back to cin.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE after WIDTH bit cycles.
- DONE->IDLE on the next cycle, or DONE->RUN if start is high in DONE.
REQ-014 On an accepted start, the block SHALL:
- load op_a and op_b into shift registers;
- load cin into the carry flop;
- clear the bit counter;
- leave sum and cout unchanged until the result is written.
REQ-015 In each RUN cycle the block SHALL:
- apply the current LSBs of A and B and the carry flop to the adder cell;
- shift the cell sum into the result MSB;
- store the cell carry-out in the carry flop;
- shift A and B right by one;
- increment the counter.
REQ-016 Latency SHALL be fixed: for start accepted at edge t, busy is high during cycles t+1..t+WIDTH, and done is high only in cycle t+WIDTH+1.
REQ-017 sum SHALL equal (op_a + op_b + cin) mod 2^WIDTH, and cout SHALL equal bit WIDTH of that sum; both SHALL be valid from the cycle done is high.
REQ-018 start while busy SHALL be ignored: no restart and no operand capture.
REQ-019 The counter SHALL be ceil(log2(WIDTH+1)) bits wide; the RUN exit SHALL compare against WIDTH-1, with no wrap-around.

Reset
REQ-020 While reset is high, the block SHALL:
- go to IDLE;
- drive busy=0, done=0, sum=0, cout=0;
- clear the shift registers, carry flop and counter.
Reset SHALL take priority over start in the same cycle.
REQ-021 Reset asserted mid-RUN SHALL abort the operation; no done pulse and no partial result SHALL appear afterwards.

Configuration
REQ-022 With macro FABRIC_SERIAL_ADDER_SUB_EN defined:
- an extra input port sub (1 bit) SHALL exist;
- when sub=1 on an accepted start, op_b SHALL be captured inverted and the carry flop loaded with 1, ignoring cin;
- sum SHALL then equal op_a - op_b mod 2^WIDTH, and cout=1 SHALL mean no borrow.
REQ-023 Without FABRIC_SERIAL_ADDER_SUB_EN, port sub SHALL be absent and behaviour SHALL be addition only (REQ-017).

Structure
REQ-024 A shared package fabric_serial_adder_pkg SHALL hold:
- the FSM state enum (IDLE, RUN, DONE);
- the counter-width function;
- the default WIDTH constant.
REQ-025 The only sub-module SHALL be one instance of the fabric full-adder primitive ADDF (ports A, B, CI, SUM, CO); all sequencing SHALL live in the top module.

Verification
REQ-026 WIDTH=8, op_a=0x5A, op_b=0x3C, cin=0 -> sum=0x96, cout=0; done exactly 9 cycles after the start edge; busy high for 8 cycles.
REQ-027 op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1; op_a=0xFF, op_b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-028 start pulsed at RUN cycle 3 with op_a=0x11 -> ignored; the original result 0x96 is still produced at the original done cycle.
REQ-029 reset at RUN cycle 4 -> next cycle IDLE with sum=0 and cout=0; no done pulse within 20 cycles; a later start completes normally.
REQ-030 start held high in the DONE cycle with new operands 0x01+0x02 -> immediate RUN; sum=0x03 exactly 9 cycles later; the previous result stays held during RUN.
REQ-031 With FABRIC_SERIAL_ADDER_SUB_EN: sub=1, op_a=0x10, op_b=0x01 -> sum=0x0F, cout=1; op_a=0x00, op_b=0x01 -> sum=0xFF, cout=0.
